// File: rtl/matmul_result_streamer.sv
`default_nettype none
// ============================================================================
// Module      : matmul_result_streamer
// Description : Captures a finished MxN accumulator matrix in one cycle and
//               streams it row-major over an AXI4-Stream master, converting
//               each element from ACC_W to OUT_W (sign-extend, clamp or
//               truncate).
// Revision    : 1.0 - initial release
// ============================================================================
module matmul_result_streamer #(
    parameter int ACC_W = 32,
    parameter int OUT_W = 32,
    parameter int M     = 2,
    parameter int N     = 2,
    parameter int SAT   = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cap_valid,
    output logic                    cap_ready,
    input  logic signed [ACC_W-1:0] C [M][N],
    output logic [OUT_W-1:0]        m_axis_tdata,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic                    m_axis_tlast,
    output logic                    busy
);

    localparam int c_DEPTH = M * N;
    localparam int c_IDX_W = $clog2(c_DEPTH) + 1;
    localparam int c_SEL_W = (c_DEPTH > 1) ? $clog2(c_DEPTH) : 1;
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(c_DEPTH - 1);

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_STREAM = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [c_IDX_W-1:0]      r_idx;
    logic [c_IDX_W-1:0]      w_idx_nxt;
    logic signed [ACC_W-1:0] r_buf [c_DEPTH];
    logic signed [ACC_W-1:0] w_sel;
    logic [OUT_W-1:0]        w_conv;
    logic                    w_capture;

    assign w_capture = cap_valid && cap_ready;

    // Snapshot the whole matrix in row-major order so the datapath may clear C
    always_ff @(posedge clk) begin
        if (w_capture) begin
            for (int i = 0; i < M; i++) begin
                for (int j = 0; j < N; j++) begin
                    r_buf[i*N + j] <= C[i][j];
                end
            end
        end
    end

    assign w_sel = r_buf[r_idx[c_SEL_W-1:0]];

    generate
        if (OUT_W >= ACC_W) begin : g_sext
            assign w_conv = OUT_W'(w_sel);
        end else if (SAT != 0) begin : g_sat
            localparam logic signed [ACC_W-1:0] c_MAX =
                {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
            localparam logic signed [ACC_W-1:0] c_MIN =
                {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
            // Clamp out-of-range values to the most positive / negative word
            always_comb begin
                if (w_sel > c_MAX) begin
                    w_conv = c_MAX[OUT_W-1:0];
                end else if (w_sel < c_MIN) begin
                    w_conv = c_MIN[OUT_W-1:0];
                end else begin
                    w_conv = w_sel[OUT_W-1:0];
                end
            end
        end else begin : g_trunc
            assign w_conv = w_sel[OUT_W-1:0];
        end
    endgenerate

    // State and element index registers; reset aborts any stream in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    // Next-state logic and stream outputs; idle outputs are all zero
    always_comb begin
        w_state_nxt   = r_state;
        w_idx_nxt     = r_idx;
        cap_ready     = 1'b0;
        busy          = 1'b0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        m_axis_tdata  = '0;
        case (r_state)
            S_IDLE: begin
                cap_ready = !rst;
                if (cap_valid && !rst) begin
                    w_state_nxt = S_STREAM;
                    w_idx_nxt   = '0;
                end
            end
            S_STREAM: begin
                busy          = 1'b1;
                m_axis_tvalid = 1'b1;
                m_axis_tdata  = w_conv;
                m_axis_tlast  = (r_idx == c_LAST_IDX);
                if (m_axis_tready) begin
                    if (r_idx == c_LAST_IDX) begin
                        w_state_nxt = S_IDLE;
                        w_idx_nxt   = '0;
                    end else begin
                        w_idx_nxt = r_idx + c_IDX_W'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_idx_nxt   = '0;
            end
        endcase
    end

`ifndef SYNTHESIS
    a_hold_under_stall: assert property (@(posedge clk) disable iff (rst)
        (m_axis_tvalid && !m_axis_tready) |=>
            ($stable(m_axis_tdata) && $stable(m_axis_tlast)));

    a_ready_busy_excl: assert property (@(posedge clk) !(cap_ready && busy));
`endif

endmodule
`default_nettype wire

// File: tb/tb_matmul_result_streamer.sv
`default_nettype none
// ============================================================================
// Module      : tb_matmul_result_streamer
// Description : Self-checking bench: 32-bit, 16-bit saturating and 16-bit
//               truncating instances share stimulus; expected words are queued
//               on capture and compared on every valid output cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_matmul_result_streamer;

    typedef struct {
        int         c[4];
        logic [15:0] pat;
        int         esat[4];
        int         etr[4];
    } vec_t;

    typedef struct packed {
        logic [31:0] d32;
        logic [15:0] dsat;
        logic [15:0] dtr;
        logic        last;
        logic [1:0]  pos;
    } exp_t;

    logic clk;
    logic rst;
    logic cap_valid;
    logic tready;
    logic signed [31:0] C [2][2];

    logic        cap_ready, busy, tvalid, tlast;
    logic [31:0] tdata;
    logic        cr_s, busy_s, tv_s, tl_s;
    logic [15:0] td_s;
    logic        cr_t, busy_t, tv_t, tl_t;
    logic [15:0] td_t;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   ncap = 0;
    int   last_cap_cyc = 0;
    logic first_seen = 1'b0;
    exp_t sb[$];
    int   first_cycs[$];
    int   tlast_cycs[$];
    vec_t tbl[4];
    vec_t pending;
    exp_t e_cap;
    exp_t e_mon;

    matmul_result_streamer #(.ACC_W(32), .OUT_W(32), .M(2), .N(2), .SAT(1)) u_dut (
        .clk(clk), .rst(rst), .cap_valid(cap_valid), .cap_ready(cap_ready), .C(C),
        .m_axis_tdata(tdata), .m_axis_tvalid(tvalid), .m_axis_tready(tready),
        .m_axis_tlast(tlast), .busy(busy));

    matmul_result_streamer #(.ACC_W(32), .OUT_W(16), .M(2), .N(2), .SAT(1)) u_sat (
        .clk(clk), .rst(rst), .cap_valid(cap_valid), .cap_ready(cr_s), .C(C),
        .m_axis_tdata(td_s), .m_axis_tvalid(tv_s), .m_axis_tready(tready),
        .m_axis_tlast(tl_s), .busy(busy_s));

    matmul_result_streamer #(.ACC_W(32), .OUT_W(16), .M(2), .N(2), .SAT(0)) u_trunc (
        .clk(clk), .rst(rst), .cap_valid(cap_valid), .cap_ready(cr_t), .C(C),
        .m_axis_tdata(td_t), .m_axis_tvalid(tv_t), .m_axis_tready(tready),
        .m_axis_tlast(tl_t), .busy(busy_t));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Output monitor and capture scoreboard
    always @(negedge clk) begin
        if (!rst) begin
            if (tvalid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_word", 32'(tvalid), 32'd0);
                end else begin
                    e_mon = sb[0];
                    chk("tdata32", tdata, e_mon.d32);
                    chk("tdata_sat16", {16'h0, td_s}, {16'h0, e_mon.dsat});
                    chk("tdata_trunc16", {16'h0, td_t}, {16'h0, e_mon.dtr});
                    chk("tlast", 32'(tlast), 32'(e_mon.last));
                    chk("valid_all_inst", {30'h0, tv_s, tv_t}, 32'd3);
                    if (e_mon.pos == 2'd0 && !first_seen) begin
                        first_seen = 1'b1;
                        first_cycs.push_back(cyc);
                        chk("first_latency", 32'(cyc), 32'(last_cap_cyc + 1));
                    end
                    if (tready) begin
                        if (e_mon.last) tlast_cycs.push_back(cyc);
                        void'(sb.pop_front());
                        first_seen = 1'b0;
                    end
                end
            end else begin
                chk("tlast_without_valid", 32'(tlast), 32'd0);
            end
            if (cap_valid && cap_ready) begin
                ncap++;
                last_cap_cyc = cyc;
                for (int i = 0; i < 4; i++) begin
                    e_cap.d32  = pending.c[i];
                    e_cap.dsat = 16'(pending.esat[i]);
                    e_cap.dtr  = 16'(pending.etr[i]);
                    e_cap.last = (i == 3);
                    e_cap.pos  = 2'(i);
                    sb.push_back(e_cap);
                end
            end
        end
    end

    task automatic set_simple(input int a, input int b, input int c, input int d);
        pending.c    = '{a, b, c, d};
        pending.esat = '{a, b, c, d};
        pending.etr  = '{a, b, c, d};
        pending.pat  = 16'hFFFF;
    endtask

    task automatic drive_c();
        for (int i = 0; i < 4; i++) C[i/2][i%2] = pending.c[i];
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns just after the posedge on which the capture handshake occurred
    task automatic wait_cap(input int target);
        for (int g = 0; g < 40 && ncap < target; g++) @(posedge clk);
        chk("capture_timeout", 32'(ncap >= target), 32'd1);
        #1;
    endtask

    task automatic drain(input logic [15:0] pat);
        for (int s = 0; s < 64 && sb.size() != 0; s++) begin
            tready = pat[s % 16];
            @(posedge clk);
            #1;
        end
        chk("drain_timeout", 32'(sb.size()), 32'd0);
        tready = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1; cap_valid = 1'b0; tready = 1'b1;
        for (int i = 0; i < 4; i++) C[i/2][i%2] = 0;
        set_simple(0, 0, 0, 0);

        tbl[0].c = '{1, 2, 3, 4};    tbl[0].pat = 16'hFFFF;
        tbl[0].esat = '{1, 2, 3, 4}; tbl[0].etr = '{1, 2, 3, 4};
        tbl[1].c = '{1, 2, 3, 4};    tbl[1].pat = 16'hFFD9;
        tbl[1].esat = '{1, 2, 3, 4}; tbl[1].etr = '{1, 2, 3, 4};
        tbl[2].c = '{40000, -40000, 32767, -32768}; tbl[2].pat = 16'hFFFF;
        tbl[2].esat = '{32767, -32768, 32767, -32768};
        tbl[2].etr  = '{-25536, 25536, 32767, -32768};
        tbl[3].c = '{-5, 100000, -100000, 0}; tbl[3].pat = 16'h5555;
        tbl[3].esat = '{-5, 32767, -32768, 0};
        tbl[3].etr  = '{-5, -31072, 31072, 0};

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_tvalid", 32'(tvalid), 32'd0);
        chk("rst_tlast", 32'(tlast), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_tdata", tdata, 32'd0);
        chk("rst_cap_ready", 32'(cap_ready), 32'd0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("idle_cap_ready", 32'(cap_ready), 32'd1);
        tick();

        // Table-driven matrices
        for (int k = 0; k < 4; k++) begin
            pending = tbl[k];
            first_cycs.delete();
            tlast_cycs.delete();
            drive_c();
            cap_valid = 1'b1;
            n = ncap;
            wait_cap(n + 1);
            cap_valid = 1'b0;
            drain(tbl[k].pat);
            @(negedge clk);
            chk("cap_ready_after", 32'(cap_ready), 32'd1);
            if (tbl[k].pat == 16'hFFFF) begin
                chk("full_span", 32'(tlast_cycs[0] - first_cycs[0]), 32'd3);
            end
            tick();
        end

        // Capture isolation; cap_valid during STREAM waits for IDLE
        first_cycs.delete();
        tlast_cycs.delete();
        set_simple(5, 6, 7, 8);
        drive_c();
        cap_valid = 1'b1;
        n = ncap;
        wait_cap(n + 1);
        set_simple(0, 0, 0, 0);
        drive_c();
        wait_cap(n + 2);
        cap_valid = 1'b0;
        drain(16'hFFFF);
        chk("iso_gap", 32'(first_cycs[1] - tlast_cycs[0]), 32'd2);
        tick();

        // Back-to-back distinct matrices
        first_cycs.delete();
        tlast_cycs.delete();
        set_simple(11, 22, 33, 44);
        drive_c();
        cap_valid = 1'b1;
        n = ncap;
        wait_cap(n + 1);
        set_simple(-1, -2, -3, -4);
        drive_c();
        wait_cap(n + 2);
        cap_valid = 1'b0;
        drain(16'hFFFF);
        chk("b2b_firsts", 32'(first_cycs.size()), 32'd2);
        chk("b2b_lasts", 32'(tlast_cycs.size()), 32'd2);
        chk("b2b_gap", 32'(first_cycs[1] - tlast_cycs[0]), 32'd2);
        tick();

        // Reset mid-stream after two words accepted
        set_simple(13, 14, 15, 16);
        drive_c();
        cap_valid = 1'b1;
        tready = 1'b1;
        n = ncap;
        wait_cap(n + 1);
        cap_valid = 1'b0;
        for (int g = 0; g < 20 && sb.size() > 2; g++) @(posedge clk);
        #1;
        chk("abort_two_accepted", 32'(sb.size()), 32'd2);
        rst = 1'b1;
        tready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("abort_tvalid", 32'(tvalid), 32'd0);
        chk("abort_tlast", 32'(tlast), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_cap_ready", 32'(cap_ready), 32'd0);
        chk("abort_sat_tvalid", 32'(tv_s), 32'd0);
        sb.delete();
        first_seen = 1'b0;
        tick();
        rst = 1'b0;
        tready = 1'b1;
        @(negedge clk);
        chk("post_rst_cap_ready", 32'(cap_ready), 32'd1);
        tick();
        set_simple(21, 22, 23, 24);
        drive_c();
        cap_valid = 1'b1;
        n = ncap;
        wait_cap(n + 1);
        cap_valid = 1'b0;
        drain(16'hFFFF);
        tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/matmul_result_streamer.md
Name: matmul_result_streamer

Overview:
- Downstream of the MAC datapath: captures the finished M×N accumulator matrix C in one cycle.
- Serialises it row-major onto an AXI4-Stream master, with optional saturation from ACC_W to OUT_W.
- Decouples the datapath from output backpressure, so the controller may clear the accumulators once capture is acknowledged.

Parameters:
- ACC_W, 32, width of each signed accumulator element of C
- OUT_W, 32, width of each streamed output word (signed)
- M, 2, rows of C
- N, 2, columns of C
- SAT, 1, 1 = saturate when OUT_W < ACC_W; 0 = truncate to low OUT_W bits

Ports:
- clk  input  1  clock, all logic on rising edge
- rst  input  1  synchronous reset, active-high
- cap_valid  input  1  C holds a finished result; capture request
- cap_ready  output  1  block can capture C this cycle
- C  input  signed ACC_W [M][N]  accumulator matrix from datapath
- m_axis_tdata  output  OUT_W  current output element
- m_axis_tvalid  output  1  tdata valid
- m_axis_tready  input  1  downstream accepts word
- m_axis_tlast  output  1  marks element C[M-1][N-1]
- busy  output  1  a matrix is being streamed

Behaviour:
- Single clock domain. Reset is synchronous and active-high. One cycle with rst=1 forces:
  - state=IDLE, idx=0
  - m_axis_tvalid=0, m_axis_tlast=0, busy=0, m_axis_tdata=0
  - cap_ready=0 while rst is high.
- Buffer contents need not be reset.
- States:
  - IDLE: cap_ready=1, tvalid=0, busy=0.
    - On cap_valid && cap_ready: latch all M*N elements of C into the internal buffer, idx=0, next state=STREAM.
    - cap_valid while not ready is ignored (no capture, no error).
  - STREAM: cap_ready=0, busy=1, tvalid=1.
    - tdata = conv(buf[idx]), with idx = i*N + j (row-major).
    - On tvalid && tready: if idx == M*N-1, go to IDLE and reset idx to 0; else idx += 1.
- Latency:
  - First word: tvalid is high in the cycle after the capture handshake.
  - Steady state: one word per cycle while tready=1, so a full matrix takes M*N cycles.
- Backpressure: while tvalid=1 and tready=0, tdata, tlast and idx hold stable (AXI rule). tvalid never drops before its handshake.
- tlast: high exactly when state==STREAM and idx==M*N-1; low otherwise.
- cap_ready returns high the cycle after the final handshake.
  - A cap_valid held high across the final beat is captured in that next cycle.
  - Minimum spacing: 1 idle cycle between the last word of one matrix and the first word of the next.
- Capture isolation: changes on C after capture have no effect on the streamed words.
- conv(x), width rules:
  - OUT_W >= ACC_W: sign-extend.
  - OUT_W < ACC_W, SAT=1: clamp to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - OUT_W < ACC_W, SAT=0: take x[OUT_W-1:0].
- idx counter width: $clog2(M*N)+1; it must not wrap past M*N-1.
- Reset mid-stream:
  - Abort immediately; tvalid=0 in the cycle after the rst edge.
  - No tlast is emitted for the aborted matrix; the remaining words are discarded.
- Assertions:
  - tdata/tlast stable under tvalid && !tready.
  - cap_ready && busy never both high.

Test Plan:
- Basic 2×2, ACC_W=OUT_W=32: C={{1,2},{3,4}}, cap_valid pulse, tready=1 → words 1,2,3,4 on 4 consecutive cycles starting the cycle after capture; tlast only on 4; cap_ready=1 the cycle after.
- Backpressure: same C, tready pattern 1,0,0,1,1,0,1 → word 2 held stable for the 2 stall cycles; all 4 words delivered in order; tlast on word 4 only.
- Capture isolation: capture C={{5,6},{7,8}}, then change C to all 0 during STREAM → stream still 5,6,7,8; cap_valid asserted during STREAM is ignored until IDLE.
- Saturation, OUT_W=16, SAT=1: C={{40000,-40000},{32767,-32768}} → 32767, -32768, 32767, -32768. With SAT=0: 40000 → -25536 (0x9C40).
- Back-to-back: cap_valid held high with two different matrices, tready=1 → second matrix's first word appears exactly 2 cycles after the first matrix's tlast beat; no words lost or duplicated.
- Reset mid-stream: assert rst after word 2 of 4 is accepted → tvalid=0, tlast=0, busy=0 next cycle; after rst drops, cap_ready=1 and a new capture streams from element [0][0].
